// File: rtl/xbus_ram_bridge_pkg.sv
// xbus_ram_bridge_pkg: FSM state encoding and default RAM/hole window limits for the Xbus RAM bridge
package xbus_ram_bridge_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;
  localparam logic [21:0] DEF_RAM_LIMIT  = 22'o11000000;
  localparam logic [21:0] DEF_HOLE_LIMIT = 22'o11100000;
endpackage

// File: rtl/xbus_watchdog.sv
// xbus_watchdog: saturating access watchdog
//   clk, reset_n : clock, async active-low reset
//   clr          : zero the counter (idle)
//   en           : count one cycle of an outstanding access
//   expired      : this edge brings the count to TIMEOUT
module xbus_watchdog #(
  parameter int              TO_W    = 8,
  parameter logic [TO_W-1:0] TIMEOUT = '1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TO_W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != TIMEOUT) cnt <= cnt + 1'b1;
  end
  assign expired = en && (cnt == TIMEOUT - 1'b1);
endmodule

// File: rtl/xbus_ram_bridge.sv
// xbus_ram_bridge: registered Xbus-to-SDRAM bridge with RAM window, ack-only hole window and access watchdog
//   Xbus side   : addr, datain, req, write in; dataout, ack, err out; decode is combinational
//   SDRAM side  : sdram_addr, sdram_data_out, sdram_req, sdram_write out; sdram_data_in, sdram_ready, sdram_done in
module xbus_ram_bridge
  import xbus_ram_bridge_pkg::*;
#(
  parameter int                ADDR_W     = 22,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RAM_LIMIT  = DEF_RAM_LIMIT,
  parameter logic [ADDR_W-1:0] HOLE_LIMIT = DEF_HOLE_LIMIT,
  parameter int                TIMEOUT    = 255,
  parameter int                TO_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] datain,
  input  logic              req,
  input  logic              write,
  output logic [DATA_W-1:0] dataout,
  output logic              ack,
  output logic              err,
  output logic              decode,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_data_out,
  input  logic [DATA_W-1:0] sdram_data_in,
  output logic              sdram_req,
  output logic              sdram_write,
  input  logic              sdram_ready,
  input  logic              sdram_done
);
  state_t state;
  logic   expired;
  assign decode = addr < HOLE_LIMIT;
  xbus_watchdog #(.TO_W(TO_W), .TIMEOUT(TO_W'(TIMEOUT))) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state == IDLE),
    .en      (state == RD || state == WR),
    .expired (expired)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      ack            <= 1'b0;
      err            <= 1'b0;
      sdram_req      <= 1'b0;
      sdram_write    <= 1'b0;
      dataout        <= '0;
      sdram_addr     <= '0;
      sdram_data_out <= '0;
    end else begin
      case (state)
        IDLE: if (req && decode) begin
          sdram_addr     <= addr;
          sdram_data_out <= datain;
          if (addr >= RAM_LIMIT) begin
            // hole: ack immediately, reads return zero, writes are dropped
            dataout <= '0;
            ack     <= 1'b1;
            state   <= ACK;
          end else if (write) begin
            sdram_write <= 1'b1;
            state       <= WR;
          end else begin
            sdram_req <= 1'b1;
            state     <= RD;
          end
        end
        RD: if (sdram_ready || expired) begin
          // completion beats a simultaneous timeout; a master that gave up gets no ack
          sdram_req <= 1'b0;
          dataout   <= sdram_ready ? sdram_data_in : '1;
          err       <= req && !sdram_ready;
          ack       <= req;
          state     <= req ? ACK : IDLE;
        end
        WR: if (sdram_done || expired) begin
          sdram_write <= 1'b0;
          if (!sdram_done) dataout <= '1;
          err         <= req && !sdram_done;
          ack         <= req;
          state       <= req ? ACK : IDLE;
        end
        default: if (!req) begin
          ack   <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_xbus_ram_bridge.sv
// tb_xbus_ram_bridge: directed scoreboard bench for xbus_ram_bridge
module tb_xbus_ram_bridge;
  typedef struct {
    logic [31:0] d;
    logic        e;
    bit          chk_d;
  } exp_t;
  logic        clk = 0;
  logic        reset_n = 0;
  logic [21:0] addr = '0;
  logic [31:0] datain = '0;
  logic        req = 0;
  logic        write = 0;
  logic [31:0] dataout;
  logic        ack, err, decode;
  logic [21:0] sdram_addr;
  logic [31:0] sdram_data_out;
  logic [31:0] sdram_data_in = '0;
  logic        sdram_req, sdram_write;
  logic        sdram_ready = 0;
  logic        sdram_done = 0;
  int          checks = 0;
  int          errors = 0;
  int          lat = 0;
  int          wcnt = 0;
  logic [31:0] rd_data = '0;
  logic        ack_q = 0;
  exp_t        q[$];
  xbus_ram_bridge #(.TIMEOUT(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .addr           (addr),
    .datain         (datain),
    .req            (req),
    .write          (write),
    .dataout        (dataout),
    .ack            (ack),
    .err            (err),
    .decode         (decode),
    .sdram_addr     (sdram_addr),
    .sdram_data_out (sdram_data_out),
    .sdram_data_in  (sdram_data_in),
    .sdram_req      (sdram_req),
    .sdram_write    (sdram_write),
    .sdram_ready    (sdram_ready),
    .sdram_done     (sdram_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // SDRAM model: completes (lat+1) cycles after the strobe rises
  always @(negedge clk) begin
    wcnt = (sdram_req || sdram_write) ? wcnt + 1 : 0;
    sdram_ready = sdram_req && (wcnt == lat + 1);
    sdram_done = sdram_write && (wcnt == lat + 1);
    sdram_data_in = rd_data;
  end
  // monitor: pop the expected response on every rising ack
  always @(negedge clk) begin
    if (sdram_req || sdram_write) chk("strobe_excl", {63'd0, sdram_req && sdram_write}, 64'd0);
    if (ack && !ack_q) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", 64'd1, 64'd0);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("ack_err", {63'd0, err}, {63'd0, x.e});
        if (x.chk_d) chk("ack_data", {32'd0, dataout}, {32'd0, x.d});
      end
    end
    ack_q = ack;
  end
  task automatic access(input string name, input logic [21:0] a, input logic w, input logic [31:0] d,
                        input int l, input logic exp_dec, input int exp_strobe, input bit exp_ack,
                        input logic [31:0] exp_d, input logic exp_e, input int budget);
    int n = 0;
    int lat_c = 0;
    bit got = 0;
    bit saw = 0;
    @(negedge clk);
    addr = a; write = w; datain = d; lat = l; rd_data = exp_d; req = 1;
    if (exp_ack) q.push_back('{exp_d, exp_e, !w});
    #1 chk({name, "_decode"}, {63'd0, decode}, {63'd0, exp_dec});
    for (int c = 1; c <= budget && !got; c++) begin
      @(negedge clk);
      if (sdram_req || sdram_write) n++;
      if (w && sdram_write && !saw) begin
        saw = 1;
        chk({name, "_wdata"}, {32'd0, sdram_data_out}, {32'd0, d});
        chk({name, "_waddr"}, {42'd0, sdram_addr}, {42'd0, a});
      end
      if (ack) begin
        got = 1;
        lat_c = c;
      end
    end
    chk({name, "_strobes"}, 64'(n), 64'(exp_strobe));
    chk({name, "_ack"}, {63'd0, got}, {63'd0, exp_ack});
    if (got) begin
      chk({name, "_latency"}, 64'(lat_c), 64'(exp_strobe + 1));
      repeat (2) @(negedge clk);
      chk({name, "_ack_held"}, {63'd0, ack}, 64'd1);
    end
    req = 0;
    @(negedge clk);
    chk({name, "_ack_clear"}, {62'd0, ack, err}, 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end
  initial begin
    #23;
    chk("reset_outs", {sdram_req, sdram_write, ack, err, 28'd0, dataout}, 64'd0);
    reset_n = 1;
    access("rd100", 22'o100, 0, '0, 3, 1, 4, 1, 32'h1234_5678, 0, 40);
    access("wr200", 22'o200, 1, 32'hDEAD_BEEF, 2, 1, 3, 1, 32'h0, 0, 40);
    access("hole", 22'o11000010, 0, '0, 0, 1, 0, 1, 32'h0, 0, 40);
    access("outside", 22'o11100000, 0, '0, 0, 0, 0, 0, 32'h0, 0, 20);
    access("timeout", 22'o300, 0, '0, 1000, 1, 8, 1, 32'hFFFF_FFFF, 1, 40);
    access("after_to", 22'o301, 0, '0, 1, 1, 2, 1, 32'hCAFE_0001, 0, 40);
    @(negedge clk);
    addr = 22'o400; write = 0; lat = 1000; req = 1;
    repeat (3) @(negedge clk);
    chk("midrd_strobe", {63'd0, sdram_req}, 64'd1);
    #2 reset_n = 0;
    #1 chk("async_reset", {sdram_req, sdram_write, ack, err, 28'd0, dataout}, 64'd0);
    chk("async_reset_addr", {42'd0, sdram_addr}, 64'd0);
    @(negedge clk);
    reset_n = 1; req = 0;
    access("post_reset", 22'o401, 0, '0, 0, 1, 1, 1, 32'h0BAD_F00D, 0, 40);
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
